// File: rtl/yolo_stream_pkg.sv
// Shared definitions for the yolo core-side stream blocks.
//   - Default stream widths and the consumer burst length.
//   - Bit offsets of the packed {last, user, strb, data} FIFO word.
//   - Encoding of the isif burst-gate state.
package yolo_stream_pkg;

  localparam int TBITS_DEF     = 32;
  localparam int TBYTE_DEF     = 4;
  localparam int BURST_LEN_DEF = 8;

  // Packed word layout, data in the low bits:
  //   [tbits-1:0]              data
  //   [tbits+tbyte-1:tbits]    strb
  //   [tbits+tbyte]            user
  //   [tbits+tbyte+1]          last
  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int strb_lsb(input int tbits);
    return tbits;
  endfunction

  function automatic int user_bit(input int tbits, input int tbyte);
    return tbits + tbyte;
  endfunction

  function automatic int last_bit(input int tbits, input int tbyte);
    return tbits + tbyte + 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } gate_state_e;

endpackage

// File: rtl/yolo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst     : clock, asynchronous active-high reset (pointers/count only)
//   wr_en        : write request; ignored while full
//   wr_data      : word to store
//   rd_en        : read request; ignored while empty
//   rd_data      : head word, valid whenever !empty (zero while empty)
//   count        : number of stored words
//   full, empty  : status flags decoded from count
module yolo_sync_fifo
  import yolo_stream_pkg::*;
#(
  parameter int W     = 38,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = wr_en && !full;
  assign do_pop  = rd_en && !empty;

  // Head is presented straight from storage; forced to zero when nothing is
  // buffered so the port reads as cleared after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers are exactly AW bits wide, so DEPTH-1 wraps to 0 on increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/yolo_isif_src.sv
// AXI4-Stream slave to core-side FWFT read port (isif_*).
// The core reads a fixed burst of BURST_LEN words once it sees isif_empty_n,
// so empty_n is only armed once a full burst or a tlast-terminated packet
// is buffered.
//   s_axis_*        : stream input; tready = !full
//   isif_*_dout     : head word fields (first-word-fall-through)
//   isif_empty_n    : burst available / in progress
//   isif_read       : pop head word
//   fill_level      : stored word count
//   underflow_err   : sticky, set by isif_read with nothing stored
module yolo_isif_src
  import yolo_stream_pkg::*;
#(
  parameter int TBITS     = TBITS_DEF,
  parameter int TBYTE     = TBYTE_DEF,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TBITS-1:0]       s_axis_tdata,
  input  logic [TBYTE-1:0]       s_axis_tstrb,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [TBITS-1:0]       isif_data_dout,
  output logic [TBYTE-1:0]       isif_strb_dout,
  output logic                   isif_last_dout,
  output logic                   isif_user_dout,
  output logic                   isif_empty_n,
  input  logic                   isif_read,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   underflow_err
);

  localparam int W        = TBITS + TBYTE + 2;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int BCW      = $clog2(BURST_LEN) + 1;
  localparam int DATA_LSB = data_lsb();
  localparam int STRB_LSB = strb_lsb(TBITS);
  localparam int USER_BIT = user_bit(TBITS, TBYTE);
  localparam int LAST_BIT = last_bit(TBITS, TBYTE);

  logic [W-1:0]   wr_word;
  logic [W-1:0]   head;
  logic [LW-1:0]  count;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           pop_last;
  logic [LW-1:0]  last_cnt;
  logic [BCW-1:0] burst_cnt_q;
  logic [BCW-1:0] burst_cnt_d;
  gate_state_e    state_q;
  gate_state_e    state_d;

  assign s_axis_tready = !full;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = isif_read && !empty;

  always_comb begin
    wr_word                           = '0;
    wr_word[DATA_LSB +: TBITS]        = s_axis_tdata;
    wr_word[STRB_LSB +: TBYTE]        = s_axis_tstrb;
    wr_word[USER_BIT]                 = s_axis_tuser;
    wr_word[LAST_BIT]                 = s_axis_tlast;
  end

  yolo_sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign isif_data_dout = head[DATA_LSB +: TBITS];
  assign isif_strb_dout = head[STRB_LSB +: TBYTE];
  assign isif_user_dout = head[USER_BIT];
  assign isif_last_dout = head[LAST_BIT];
  assign pop_last       = pop && head[LAST_BIT];
  assign fill_level     = count;

  // Decoded from registers only, so an asynchronous reset drops it at once.
  assign isif_empty_n   = (state_q == BURST) && !empty;

  // last_cnt tracks how many buffered words close a packet; any nonzero
  // value means a short packet can be released without a full burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_cnt      <= '0;
      underflow_err <= 1'b0;
      state_q       <= IDLE;
      burst_cnt_q   <= '0;
    end else begin
      case ({push && s_axis_tlast, pop_last})
        2'b10:   last_cnt <= last_cnt + LW'(1);
        2'b01:   last_cnt <= last_cnt - LW'(1);
        default: last_cnt <= last_cnt;
      endcase
      if (isif_read && empty) underflow_err <= 1'b1;
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // The burst counter follows isif_read rather than the qualified pop: the
  // consumer's fixed-length burst must close the gate even if it underflows.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (count >= LW'(BURST_LEN) || last_cnt != '0) begin
          state_d     = BURST;
          burst_cnt_d = BCW'(BURST_LEN);
        end
      end
      BURST: begin
        if (isif_read) begin
          burst_cnt_d = burst_cnt_q - BCW'(1);
          if (burst_cnt_q == BCW'(1) || pop_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_yolo_isif_src.sv
// Self-checking bench for yolo_isif_src (default parameters).
module tb_yolo_isif_src;

  localparam int TBITS     = 32;
  localparam int TBYTE     = 4;
  localparam int DEPTH     = 16;
  localparam int BURST_LEN = 8;

  typedef struct packed {
    logic             last;
    logic             user;
    logic [TBYTE-1:0] strb;
    logic [TBITS-1:0] data;
  } word_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [TBITS-1:0] s_axis_tdata = '0;
  logic [TBYTE-1:0] s_axis_tstrb = '0;
  logic             s_axis_tlast = 1'b0;
  logic             s_axis_tuser = 1'b0;
  logic             s_axis_tvalid = 1'b0;
  logic             s_axis_tready;
  logic [TBITS-1:0] isif_data_dout;
  logic [TBYTE-1:0] isif_strb_dout;
  logic             isif_last_dout;
  logic             isif_user_dout;
  logic             isif_empty_n;
  logic             isif_read = 1'b0;
  logic [4:0]       fill_level;
  logic             underflow_err;

  int    errors = 0;
  int    checks = 0;
  word_t mq[$];     // reference contents, head at index 0

  yolo_isif_src #(
    .TBITS(TBITS), .TBYTE(TBYTE), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .isif_data_dout(isif_data_dout), .isif_strb_dout(isif_strb_dout),
    .isif_last_dout(isif_last_dout), .isif_user_dout(isif_user_dout),
    .isif_empty_n(isif_empty_n), .isif_read(isif_read),
    .fill_level(fill_level), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic word_t mk(input logic [TBITS-1:0] d, input logic l);
    word_t w;
    w.data = d; w.strb = 4'hF; w.user = 1'b0; w.last = l;
    return w;
  endfunction

  function automatic word_t rnd_word();
    word_t w;
    w.data = $urandom; w.strb = 4'($urandom); w.user = 1'($urandom);
    w.last = ($urandom_range(7) == 0);
    return w;
  endfunction

  function automatic word_t head_now();
    word_t w;
    w.data = isif_data_dout; w.strb = isif_strb_dout;
    w.user = isif_user_dout; w.last = isif_last_dout;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; the model applies FIFO semantics to its queue.
  task automatic cycle(input logic v, input word_t w, input logic rd);
    bit acc;
    s_axis_tvalid = v;
    s_axis_tdata  = w.data;
    s_axis_tstrb  = w.strb;
    s_axis_tuser  = w.user;
    s_axis_tlast  = w.last;
    isif_read     = rd;
    acc = v && (mq.size() < DEPTH);
    if (rd && mq.size() != 0) void'(mq.pop_front());
    if (acc) mq.push_back(w);
    step();
    s_axis_tvalid = 1'b0;
    isif_read     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mq.delete();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mq.delete();
    step();
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b want 1", s_axis_tready); end
    checks++; if (isif_empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n: got %b want 0", isif_empty_n); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", underflow_err); end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
    checks++; if (head_now() !== '0) begin errors++; $display("FAIL reset_head: got %h want 0", head_now()); end
    rst = 1'b0;
    step();
  endtask

  // Push BURST_LEN plain words then consume them as the core would.
  task automatic run_burst(input logic [TBITS-1:0] base);
    for (int i = 0; i < BURST_LEN; i++) cycle(1'b1, mk(base + TBITS'(i), 1'b0), 1'b0);
    checks++; if (isif_empty_n !== 1'b0) begin errors++; $display("FAIL burst_not_early: got %b want 0", isif_empty_n); end
    checks++; if (fill_level !== 5'd8) begin errors++; $display("FAIL burst_fill: got %0d want 8", fill_level); end
    cycle(1'b0, '0, 1'b0);
    checks++; if (isif_empty_n !== 1'b1) begin errors++; $display("FAIL burst_arm: got %b want 1", isif_empty_n); end
    for (int i = 0; i < BURST_LEN; i++) begin
      checks++;
      if (isif_empty_n !== 1'b1 || isif_data_dout !== base + TBITS'(i)) begin
        errors++;
        $display("FAIL burst_data[%0d]: got %h/empty_n=%b want %h/1", i, isif_data_dout, isif_empty_n, base + TBITS'(i));
      end
      cycle(1'b0, '0, 1'b1);
    end
    checks++; if (isif_empty_n !== 1'b0) begin errors++; $display("FAIL burst_end: got %b want 0", isif_empty_n); end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL burst_underflow: got %b want 0", underflow_err); end
    checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL burst_drain: got %0d want 0", fill_level); end
  endtask

  task automatic test_burst();
    do_reset();
    run_burst(32'h100);
  endtask

  task automatic test_packet();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'hA0 + TBITS'(i), i == 2), 1'b0);
    cycle(1'b0, '0, 1'b0);
    checks++; if (isif_empty_n !== 1'b1 || fill_level !== 5'd3) begin errors++; $display("FAIL pkt_arm: got empty_n=%b fill=%0d want 1/3", isif_empty_n, fill_level); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (isif_data_dout !== 32'hA0 + TBITS'(i) || isif_last_dout !== (i == 2)) begin
        errors++;
        $display("FAIL pkt_data[%0d]: got %h last=%b want %h last=%b", i, isif_data_dout, isif_last_dout, 32'hA0 + TBITS'(i), i == 2);
      end
      cycle(1'b0, '0, 1'b1);
    end
    checks++; if (isif_empty_n !== 1'b0 || underflow_err !== 1'b0) begin errors++; $display("FAIL pkt_end: got empty_n=%b uf=%b want 0/0", isif_empty_n, underflow_err); end
    cycle(1'b0, '0, 1'b1);
    checks++; if (underflow_err !== 1'b1 || fill_level !== 5'd0) begin errors++; $display("FAIL pkt_underflow: got uf=%b fill=%0d want 1/0", underflow_err, fill_level); end
    // Gate must be back in IDLE: one plain word must not open it.
    cycle(1'b1, mk(32'hBEEF, 1'b0), 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    checks++; if (isif_empty_n !== 1'b0 || underflow_err !== 1'b1) begin errors++; $display("FAIL pkt_idle: got empty_n=%b uf=%b want 0/1", isif_empty_n, underflow_err); end
  endtask

  task automatic test_full();
    word_t held;
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk($urandom, 1'b0), 1'b0);
    checks++; if (s_axis_tready !== 1'b0 || fill_level !== 5'd16) begin errors++; $display("FAIL full_flag: got tready=%b fill=%0d want 0/16", s_axis_tready, fill_level); end
    held = mk(32'h1717_1717, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, held, 1'b0);
      checks++; if (s_axis_tready !== 1'b0 || fill_level !== 5'd16) begin errors++; $display("FAIL full_hold[%0d]: got tready=%b fill=%0d want 0/16", i, s_axis_tready, fill_level); end
    end
    cycle(1'b1, held, 1'b1);
    checks++; if (s_axis_tready !== 1'b1 || fill_level !== 5'd15) begin errors++; $display("FAIL full_release: got tready=%b fill=%0d want 1/15", s_axis_tready, fill_level); end
    cycle(1'b1, held, 1'b0);
    checks++; if (fill_level !== 5'd16 || mq[mq.size()-1] !== held) begin errors++; $display("FAIL full_accept: got fill=%0d want 16", fill_level); end
    for (int i = 0; i < 40 && mq.size() != 0; i++) begin
      checks++; if (head_now() !== mq[0]) begin errors++; $display("FAIL full_drain[%0d]: got %h want %h", i, head_now(), mq[0]); end
      cycle(1'b0, '0, 1'b1);
    end
    checks++; if (fill_level !== 5'd0 || mq.size() != 0) begin errors++; $display("FAIL full_empty: got fill=%0d want 0", fill_level); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < BURST_LEN; i++) cycle(1'b1, rnd_word(), 1'b0);
    for (int i = 0; i < 40; i++) begin
      checks++; if (head_now() !== mq[0]) begin errors++; $display("FAIL b2b_head[%0d]: got %h want %h", i, head_now(), mq[0]); end
      cycle(1'b1, rnd_word(), 1'b1);
      checks++; if (fill_level !== 5'd8) begin errors++; $display("FAIL b2b_fill[%0d]: got %0d want 8", i, fill_level); end
    end
    while (mq.size() != 0) begin
      checks++; if (head_now() !== mq[0]) begin errors++; $display("FAIL b2b_drain: got %h want %h", head_now(), mq[0]); end
      cycle(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, mk(32'h500 + TBITS'(i), i == 4), 1'b0);
    cycle(1'b0, '0, 1'b0);
    checks++; if (isif_empty_n !== 1'b1 || fill_level !== 5'd5) begin errors++; $display("FAIL rstmid_armed: got empty_n=%b fill=%0d want 1/5", isif_empty_n, fill_level); end
    #2;
    rst = 1'b1;
    mq.delete();
    #1;
    checks++;
    if (isif_empty_n !== 1'b0 || fill_level !== 5'd0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: got empty_n=%b fill=%0d tready=%b want 0/0/1", isif_empty_n, fill_level, s_axis_tready);
    end
    step();
    rst = 1'b0;
    step();
    run_burst(32'h200);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      logic v, rd;
      v  = ($urandom_range(9) < 7);
      rd = (mq.size() != 0) && ($urandom_range(1) == 1);
      if (mq.size() != 0) begin
        checks++; if (head_now() !== mq[0]) begin errors++; $display("FAIL rnd_head[%0d]: got %h want %h", i, head_now(), mq[0]); end
      end
      cycle(v, rnd_word(), rd);
      checks++;
      if (fill_level !== 5'(mq.size()) || s_axis_tready !== (mq.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_fill[%0d]: got fill=%0d tready=%b want %0d/%b", i, fill_level, s_axis_tready, mq.size(), mq.size() < DEPTH);
      end
    end
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL rnd_underflow: got %b want 0", underflow_err); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_packet();
    test_full();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yolo_isif_src.md
Name: yolo_isif_src

Overview:
- Transmit end of the core-side input stream: accepts an AXI4-Stream slave and presents a first-word-fall-through (FWFT) FIFO read port (isif_*) to the accelerator core.
- The core asserts isif_read for a fixed burst of BURST_LEN consecutive cycles once it sees isif_empty_n, without re-checking empty_n.
- This block therefore arms empty_n only when a whole burst, or a tlast-terminated packet, is buffered.

Parameters:
- TBITS, 32, data width.
- TBYTE, 4, strobe width (TBITS/8).
- DEPTH, 16, FIFO entries; power of two, must be >= BURST_LEN.
- BURST_LEN, 8, words the consumer reads per burst.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axis_tdata  in  TBITS  stream data
- s_axis_tstrb  in  TBYTE  byte strobes
- s_axis_tlast  in  1  packet end
- s_axis_tuser  in  1  sideband
- s_axis_tvalid  in  1  source valid
- s_axis_tready  out  1  accept; equals !full
- isif_data_dout  out  TBITS  head word data
- isif_strb_dout  out  TBYTE  head word strobes
- isif_last_dout  out  1  head word last
- isif_user_dout  out  1  head word user
- isif_empty_n  out  1  burst available / in progress
- isif_read  in  1  pop head word
- fill_level  out  log2(DEPTH)+1  stored word count
- underflow_err  out  1  sticky; pop with no data

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - pointers, count, last_cnt = 0; state = IDLE.
  - s_axis_tready = 1; isif_empty_n = 0; underflow_err = 0; fill_level = 0.
  - isif_*_dout = 0 (head cleared).
- Storage:
  - Each entry holds {last, user, strb, data} (TBITS+TBYTE+2 bits).
  - push = tvalid && tready; pop = isif_read && count != 0.
  - count updates by push - pop in the same cycle; push and pop together leave count unchanged and are both legal.
  - full = (count == DEPTH), so a push is never accepted while full.
- FWFT: isif_*_dout = mem[rd_ptr], combinational from registered storage. A word pushed in cycle N is visible at the head from cycle N+1.
- last_cnt: number of stored words with last=1. Increments on push of a last word, decrements on pop of a last word; both in the same cycle leave it unchanged.
- Gate FSM:
  - IDLE: empty_n = 0.
    - Go to BURST when count >= BURST_LEN or last_cnt != 0.
    - Load burst_cnt = BURST_LEN.
  - BURST: empty_n = (count != 0).
    - Each pop decrements burst_cnt.
    - Go to IDLE on the pop where burst_cnt == 1, or on a pop of a last word, whichever comes first.
- Transitions are registered: empty_n rises 1 cycle after the arming condition is met, and falls the cycle after the terminating pop.
- Underflow: isif_read while count == 0.
  - Pop is ignored; pointers and count are unchanged.
  - underflow_err is set and stays set until rst.
  - burst_cnt still decrements, so the consumer's fixed burst ends the state.
- Pointer wrap: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap DEPTH-1 to 0 naturally.
- fill_level = count, registered.
- Reset mid-burst: all state is discarded; buffered words are lost and empty_n drops immediately (asynchronously).

Decomposition:
- Package yolo_stream_pkg holds:
  - TBITS/TBYTE defaults and BURST_LEN.
  - Field offsets of the packed {last, user, strb, data} word.
  - Gate state encoding: IDLE=1'b0, BURST=1'b1.
- One sub-module, yolo_sync_fifo: storage, pointers, count, full/empty, FWFT head.
- The gate FSM, last_cnt and underflow logic live in yolo_isif_src.

Test Plan:
- Push 8 words 0x100..0x107 (tlast on none), then hold isif_read for 8 cycles from the first empty_n:
  - empty_n rises the cycle after the 8th push.
  - Core receives 0x100..0x107 in order.
  - empty_n is 0 after the burst; underflow_err = 0.
- Push 3 words 0xA0..0xA2 with tlast on 0xA2:
  - empty_n arms with count = 3.
  - Reading 3 words returns the data with last_dout = 1 on 0xA2, then state returns to IDLE.
  - A 4th read in the same cycle window sets underflow_err.
- Push 16 words with the consumer stalled:
  - tready = 0 at fill_level = 16; a 17th tvalid word is held and not lost.
  - One pop re-raises tready the next cycle.
- Simultaneous push and pop every cycle for 40 words through a DEPTH=16 FIFO:
  - fill_level stays constant.
  - Data matches in order across multiple pointer wraps.
- Assert rst while BURST holds 5 words:
  - empty_n, fill_level and tready return to reset values immediately.
  - After release, a fresh 8-word burst behaves as in the first test.
